// File: rtl/sw_debounce_edge_irq_pkg.sv
// Shared register map and control-bit layout for the switch debounce/edge interrupt block.
package sw_if_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_IRQ_MASK = 2'd1,
    REG_EDGE_CAP = 2'd2,
    REG_CTRL     = 2'd3
  } reg_addr_e;

  localparam int CTRL_DB_EN = 0;
  localparam int CTRL_RISE  = 1;
  localparam int CTRL_FALL  = 2;

  localparam logic [2:0] CTRL_RESET = 3'b111;

endpackage

// File: rtl/sw_debounce_edge_irq_bit.sv
// One switch bit: multi-flop synchronizer followed by a tick-sampled stability counter.
module sw_debounce_bit
  import sw_if_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_in,
  input  logic tick,
  input  logic enable,
  output logic sw_stable
);

  localparam int CNT_W = $clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      sw_stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
      if (!enable) begin
        sw_stable <= sync;
        cnt_q     <= '0;
      end else if (tick) begin
        // Any sample that agrees with the accepted value restarts the run.
        if (sync == sw_stable) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          sw_stable <= sync;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce_edge_irq.sv
// Debounced switch input with sticky edge capture, maskable level irq and an Avalon-MM slave.
module sw_debounce_edge_irq
  import sw_if_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] sw_stable,
  output logic             irq
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [WIDTH-1:0]  stable_q;
  logic [WIDTH-1:0]  edge_cap;
  logic [WIDTH-1:0]  irq_mask;
  logic [2:0]        ctrl;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic [WIDTH-1:0]  sel;
  logic [WIDTH-1:0]  clr;
  logic              wr_en;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_in     (sw_in[i]),
      .tick      (tick),
      .enable    (ctrl[CTRL_DB_EN]),
      .sw_stable (sw_stable[i])
    );
  end

  assign wr_en = chipselect & ~write_n;
  assign rise  = sw_stable & ~stable_q;
  assign fall  = ~sw_stable & stable_q;
  assign sel   = (rise & {WIDTH{ctrl[CTRL_RISE]}}) | (fall & {WIDTH{ctrl[CTRL_FALL]}});
  assign clr   = (wr_en && address == REG_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      ctrl     <= CTRL_RESET;
    end else begin
      stable_q <= sw_stable;
      // A fresh edge in the same cycle as its W1C must not be lost.
      edge_cap <= (edge_cap & ~clr) | sel;
      if (wr_en && address == REG_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      if (wr_en && address == REG_CTRL)     ctrl     <= writedata[2:0];
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:     readdata = 32'(sw_stable);
      REG_IRQ_MASK: readdata = 32'(irq_mask);
      REG_EDGE_CAP: readdata = 32'(edge_cap);
      REG_CTRL:     readdata = {29'd0, ctrl};
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sw_debounce_edge_irq.sv
// Directed bench for sw_debounce_edge_irq with TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.
module tb_sw_debounce_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sw_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [11:0] sw_stable;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int ecount;
  logic [31:0] rdv;

  sw_debounce_edge_irq #(
    .WIDTH        (12),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_in      (sw_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sw_stable  (sw_stable),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the debounce logic acts on every 4th one.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    do begin
      @(posedge clk);
      #1;
    end while (ecount % 4 != 0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    sw_in      = '0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    rd(2'd0, rdv); chk("rst_data", rdv, 32'h0);
    rd(2'd1, rdv); chk("rst_mask", rdv, 32'h0);
    rd(2'd2, rdv); chk("rst_edge", rdv, 32'h0);
    rd(2'd3, rdv); chk("rst_ctrl", rdv, 32'h7);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_stable", 32'(sw_stable), 32'h0);

    // Bit 0 rises and is held: accepted on the third differing tick
    align();
    sw_in = 12'h001;
    step(11); chk("b0_pre_accept", 32'(sw_stable), 32'h000);
    step(1);  chk("b0_accept", 32'(sw_stable), 32'h001);
    rd(2'd2, rdv); chk("b0_edge_not_yet", rdv, 32'h0);
    step(1);
    rd(2'd2, rdv); chk("b0_edge_cap", rdv, 32'h001);
    chk("b0_irq_masked", 32'(irq), 32'h0);
    wr(2'd1, 32'h001);
    chk("b0_irq_unmasked", 32'(irq), 32'h1);
    wr(2'd2, 32'h001);
    rd(2'd2, rdv); chk("b0_w1c", rdv, 32'h0);
    chk("b0_irq_cleared", 32'(irq), 32'h0);

    // Glitch on bit 5 lasting two ticks is rejected
    align();
    sw_in = 12'h021;
    step(8);
    sw_in = 12'h001;
    step(12);
    chk("glitch_stable", 32'(sw_stable), 32'h001);
    rd(2'd2, rdv); chk("glitch_edge", rdv, 32'h0);

    // Rising-only edge select
    wr(2'd3, 32'h3);
    align();
    sw_in = 12'h000;
    step(12); chk("fall_accept", 32'(sw_stable), 32'h000);
    step(1);
    rd(2'd2, rdv); chk("fall_not_captured", rdv, 32'h0);
    align();
    sw_in = 12'h001;
    step(13);
    rd(2'd2, rdv); chk("rise_captured", rdv, 32'h001);
    chk("rise_irq", 32'(irq), 32'h1);
    wr(2'd2, 32'h001);

    // Bypass with both edges
    wr(2'd3, 32'h6);
    sw_in = 12'hA5A;
    step(2); chk("byp_pre", 32'(sw_stable), 32'h001);
    step(1); chk("byp_lat3", 32'(sw_stable), 32'hA5A);
    rd(2'd2, rdv); chk("byp_edge_not_yet", rdv, 32'h0);
    step(1);
    rd(2'd2, rdv); chk("byp_edge_both", rdv, 32'hA5B);
    chk("byp_irq", 32'(irq), 32'h1);

    // W1C of bit 3 collides with a new bit-3 edge: set wins
    sw_in = 12'hA52;
    step(3); chk("col_stable", 32'(sw_stable), 32'hA52);
    wr(2'd2, 32'h008);
    rd(2'd2, rdv); chk("col_set_wins", rdv, 32'hA5B);
    wr(2'd2, 32'hFFF);
    rd(2'd2, rdv); chk("clr_all", rdv, 32'h0);

    // Reset mid-debounce discards accumulated ticks
    sw_in = 12'h000;
    step(4);
    wr(2'd2, 32'hFFF);
    rd(2'd2, rdv); chk("pre_rst_clean", rdv, 32'h0);
    wr(2'd3, 32'h7);
    align();
    sw_in = 12'h004;
    step(8);
    reset_n = 1'b0;
    rd(2'd1, rdv); chk("mid_rst_mask", rdv, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(11); chk("rst_restart_pre", 32'(sw_stable), 32'h000);
    step(1);  chk("rst_restart_accept", 32'(sw_stable), 32'h004);
    step(1);
    rd(2'd2, rdv); chk("rst_restart_edge", rdv, 32'h004);
    chk("rst_restart_irq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
